serial_shifter: RTL and testbench

SERIAL_SHIFTER -- requirements
Module: serial_shifter

---
 rtl/serial_shifter_if.sv | 30 +++
 rtl/serial_shifter.sv | 100 ++++++++++
 tb/tb_serial_shifter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_shifter_if
// Description : Request/response bundle between a shift requester and the
//               bit-serial shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_shifter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] shamt_ext;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, op, operand, shamt_ext,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, operand, shamt_ext,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_shifter
// Description : Bit-serial shifter; SLL/SRL/SRA/pass-through, one bit per
//               clock, with flush abort and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  wire              clk,
  input  wire              rst_n,
  serial_shifter_if.slave  sif
);

  localparam logic [1:0] c_OP_SLL  = 2'b00;
  localparam logic [1:0] c_OP_SRL  = 2'b01;
  localparam logic [1:0] c_OP_SRA  = 2'b10;
  localparam logic [1:0] c_OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op_q;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_acc_shifted;
  logic             w_accept;

  // A new request is only taken when no shift is in flight and no flush.
  assign w_accept = sif.start && !sif.flush && (r_state != SHIFT);

  // State register; reset is asynchronous so an in-flight shift dies at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: flush beats everything, DONE can chain straight into SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    if (sif.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = sif.start ? SHIFT : IDLE;
        SHIFT:   w_state_nxt = (r_count == '0) ? DONE : SHIFT;
        DONE:    w_state_nxt = sif.start ? SHIFT : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // One-bit shift of the accumulator according to the captured operation.
  always_comb begin
    w_acc_shifted = r_acc;
    case (r_op_q)
      c_OP_SLL:  w_acc_shifted = {r_acc[WIDTH-2:0], 1'b0};
      c_OP_SRL:  w_acc_shifted = {1'b0, r_acc[WIDTH-1:1]};
      c_OP_SRA:  w_acc_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      c_OP_PASS: w_acc_shifted = r_acc;
      default:   w_acc_shifted = r_acc;
    endcase
  end

  // Datapath: capture on accept, shift while counting, publish on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_op_q   <= c_OP_SLL;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc   <= sif.operand;
      r_op_q  <= sif.op;
      // Pass-through never shifts, whatever the immediate says.
      r_count <= (sif.op == c_OP_PASS) ? '0 : sif.shamt_ext[SHW-1:0];
    end else if (!sif.flush && (r_state == SHIFT)) begin
      if (r_count != '0) begin
        r_acc   <= w_acc_shifted;
        r_count <= r_count - 1'b1;
      end else begin
        r_result <= r_acc;
      end
    end
  end

  assign sif.busy   = (r_state == SHIFT);
  assign sif.done   = (r_state == DONE);
  assign sif.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_shifter
// Description : Scoreboard bench for serial_shifter with randomized and
//               directed shift requests against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_shifter;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               n;
    int               cap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   busy_cnt;
  logic [WIDTH-1:0] last_exp;
  exp_t exp_q[$];

  serial_shifter_if #(.WIDTH(WIDTH)) sif ();

  serial_shifter #(.WIDTH(WIDTH), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, advanced at every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [WIDTH-1:0] got, logic [WIDTH-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endfunction

  // Reference model: shift by the full amount at once.
  function automatic exp_t model(logic [1:0] op, logic [WIDTH-1:0] opd, logic [WIDTH-1:0] sh);
    exp_t e;
    int   n;
    n = (op == 2'b11) ? 0 : int'(sh % WIDTH);
    case (op)
      2'b00:   e.res = opd << n;
      2'b01:   e.res = opd >> n;
      2'b10:   e.res = WIDTH'($signed(opd) >>> n);
      default: e.res = opd;
    endcase
    e.n   = n;
    e.cap = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.busy) busy_cnt = busy_cnt + 1;
      if (sif.done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", sif.result, e.res);
          check("latency", WIDTH'(cyc - e.cap), WIDTH'(e.n + 1));
          check("busy_cycles", WIDTH'(busy_cnt), WIDTH'(e.n + 1));
          last_exp = e.res;
        end
        busy_cnt = 0;
      end else if (!sif.busy) begin
        busy_cnt = 0;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  // Present a request; called just after a falling edge.
  task automatic send(logic [1:0] op, logic [WIDTH-1:0] opd, logic [WIDTH-1:0] sh);
    exp_t e;
    e = model(op, opd, sh);
    e.cap = cyc + 1;
    exp_q.push_back(e);
    sif.start     = 1'b1;
    sif.op        = op;
    sif.operand   = opd;
    sif.shamt_ext = sh;
    @(negedge clk);
    sif.start     = 1'b0;
    sif.operand   = $urandom;
    sif.shamt_ext = $urandom;
    sif.op        = 2'($urandom);
  endtask

  // Wait for the done pulse with a bounded cycle budget.
  task automatic wait_done();
    int n;
    n = 0;
    while (!sif.done && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!sif.done) check("done_timeout", 0, 1);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc           = 0;
    n_checks      = 0;
    n_fail        = 0;
    busy_cnt      = 0;
    last_exp      = '0;
    rst_n         = 1'b0;
    sif.start     = 1'b0;
    sif.flush     = 1'b0;
    sif.op        = 2'b00;
    sif.operand   = '0;
    sif.shamt_ext = '0;
    #1;
    check("reset_busy", WIDTH'(sif.busy), 0);
    check("reset_done", WIDTH'(sif.done), 0);
    check("reset_result", sif.result, 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Directed corner cases.
    send(2'b00, 32'h0000_0001, 32'd5);          wait_done(); idle(1);
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(); idle(1);
    send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(); idle(1);
    send(2'b00, 32'hDEAD_BEEF, 32'd0);          wait_done(); idle(1);
    send(2'b11, 32'hDEAD_BEEF, 32'd17);         wait_done(); idle(1);

    // A start during SHIFT must be ignored.
    send(2'b01, 32'hF0F0_1234, 32'd10);
    idle(3);
    sif.start   = 1'b1;
    sif.operand = 32'h1111_1111;
    sif.op      = 2'b00;
    @(negedge clk);
    sif.start   = 1'b0;
    wait_done();

    // Back-to-back: start issued in the DONE cycle.
    send(2'b10, 32'h8765_4321, 32'd3);
    wait_done();
    send(2'b00, 32'h0000_00FF, 32'd4);
    wait_done();
    idle(1);

    // Flush mid-shift at count=3: no done, result held.
    send(2'b00, 32'h0000_0003, 32'd8);
    idle(5);
    sif.flush = 1'b1;
    @(negedge clk);
    sif.flush = 1'b0;
    exp_q.delete();
    check("flush_busy", WIDTH'(sif.busy), 0);
    check("flush_done", WIDTH'(sif.done), 0);
    check("flush_result", sif.result, last_exp);
    idle(3);
    check("flush_result_held", sif.result, last_exp);

    // Start together with flush in IDLE stays IDLE.
    sif.start = 1'b1;
    sif.flush = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.flush = 1'b0;
    check("startflush_busy", WIDTH'(sif.busy), 0);
    check("startflush_done", WIDTH'(sif.done), 0);
    idle(2);

    // Asynchronous reset mid-shift.
    send(2'b01, 32'hCAFE_F00D, 32'd20);
    idle(4);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_exp = '0;
    check("rst_busy", WIDTH'(sif.busy), 0);
    check("rst_done", WIDTH'(sif.done), 0);
    check("rst_result", sif.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'b00, 32'h0000_0001, 32'd1);
    wait_done();
    check("post_reset_result", sif.result, 32'h0000_0002);
    idle(1);

    // Randomized traffic, full-width shift amounts.
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom), $urandom, $urandom);
      wait_done();
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 0)));
    end
    idle(3);
    check("scoreboard_empty", WIDTH'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
